// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// rr_mux_arbiter_pkg - FSM state type and default sizing for rr_mux_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mux_n.sv
`default_nettype none
//------------------------------------------------------------------------------
// mux_n - N:1 combinational multiplexer of W-bit lanes, selected by index
// Rev 1.0
//------------------------------------------------------------------------------
module mux_n
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int SW = $clog2(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        y = data[k*W +: W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// rr_mux_arbiter - packet-aware round-robin N:1 stream mux with output register
// Rev 1.0
//------------------------------------------------------------------------------
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  arb_state_t    r_state;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_lock;

  logic          w_free;
  logic          w_found;
  logic [SW-1:0] w_search;
  logic [SW-1:0] w_grant;
  logic          w_grant_ok;
  logic          w_xfer;
  logic          w_last;
  logic [W-1:0]  w_mux_data;

  // Search starts just after the previous packet's channel, wrapping modulo N.
  always_comb begin
    w_found  = 1'b0;
    w_search = '0;
    for (int i = 1; i <= N; i++) begin
      if (!w_found && in_valid[(int'(r_ptr) + i) % N]) begin
        w_found  = 1'b1;
        w_search = SW'((int'(r_ptr) + i) % N);
      end
    end
  end

  always_comb begin
    w_free     = !out_valid || out_ready;
    w_grant    = (r_state == HOLD) ? r_lock : w_search;
    w_grant_ok = rst_n && w_free && ((r_state == HOLD) || w_found);
    in_ready   = '0;
    if (w_grant_ok) begin
      in_ready[w_grant] = 1'b1;
    end
    w_xfer = |(in_valid & in_ready);
    w_last = in_last[w_grant];
  end

  mux_n #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_mux (
    .data (in_data),
    .sel  (w_grant),
    .y    (w_mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_ptr     <= SW'(N - 1);
      r_lock    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_data  <= w_mux_data;
        out_last  <= w_last;
        out_sel   <= w_grant;
        case (r_state)
          ARB: begin
            if (w_last) begin
              r_ptr <= w_grant;
            end else begin
              r_state <= HOLD;
              r_lock  <= w_grant;
            end
          end
          HOLD: begin
            if (w_last) begin
              r_state <= ARB;
              r_ptr   <= r_lock;
            end
          end
          default: r_state <= ARB;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_rr_mux_arbiter - directed and random checks of rr_mux_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  // Reference: last packet's channel, open lock (-1 none) and the output beat.
  int           m_ptr;
  int           m_lock;
  bit           m_ov;
  logic [W-1:0] m_od;
  bit           m_ol;
  int           m_os;
  int           open_ch;
  int           in_beats;
  int           out_beats;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = N - 1;
    m_lock    = -1;
    m_ov      = 1'b0;
    m_od      = '0;
    m_ol      = 1'b0;
    m_os      = 0;
    open_ch   = -1;
    in_beats  = 0;
    out_beats = 0;
  endtask

  function automatic int exp_grant();
    if (m_ov && !out_ready) return -1;
    if (m_lock >= 0) return m_lock;
    for (int i = 1; i <= N; i++) begin
      if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // Called at a falling edge with inputs already applied; returns at the next one.
  task automatic step();
    int           g;
    logic [N-1:0] er;
    #1;
    g  = exp_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("in_ready", in_ready, er);
    chk("ready_onehot0", ($countones(in_ready) <= 1), 1);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("out_sel", out_sel, m_os);
    end
    if (out_valid && out_ready) begin
      out_beats++;
      if (open_ch >= 0) chk("no_interleave", out_sel, open_ch);
      open_ch = out_last ? -1 : int'(out_sel);
    end
    @(posedge clk);
    if (g >= 0 && in_valid[g]) begin
      in_beats++;
      m_ov = 1'b1;
      m_od = in_data[g*W +: W];
      m_ol = in_last[g];
      m_os = g;
      if (in_last[g]) begin
        m_ptr  = g;
        m_lock = -1;
      end else begin
        m_lock = g;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int           seq[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] hold_d;
    logic [SW-1:0] hold_s;

    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    in_valid = '1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sel", out_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with single-beat packets on every channel.
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      step();
      chk("rr_seq", out_sel, seq[i]);
    end
    in_data = $urandom;
    step();
    chk("rr_seq_next", out_sel, 1);

    // Three-beat packet on channel 2 holds the grant despite other requesters.
    in_last = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom;
      step();
      chk("pkt_sel", out_sel, 2);
      chk("pkt_last", out_last, 0);
    end
    in_last = 4'b1111;
    in_data = $urandom;
    step();
    chk("pkt_end_sel", out_sel, 2);
    chk("pkt_end_last", out_last, 1);
    in_data = $urandom;
    step();
    chk("after_pkt_sel", out_sel, 3);

    // Backpressure: nothing accepted, output beat frozen.
    out_ready = 1'b0;
    hold_d = out_data;
    hold_s = out_sel;
    repeat (5) begin
      in_data = $urandom;
      step();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, hold_d);
      chk("stall_sel", out_sel, hold_s);
    end
    out_ready = 1'b1;
    in_data = $urandom;
    step();
    chk("resume_sel", out_sel, 0);

    // Lone requester on the top channel is regranted through the wrap.
    in_valid = 4'b1000;
    repeat (4) begin
      in_data = $urandom;
      step();
      chk("wrap_sel", out_sel, 3);
    end

    // Reset in the middle of a packet on channel 1.
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    in_data  = $urandom;
    step();
    chk("hold1_sel", out_sel, 1);
    in_valid = 4'b1111;
    in_data  = $urandom;
    step();
    chk("hold1_keep", out_sel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    in_data  = $urandom;
    step();
    chk("post_rst_sel", out_sel, 0);

    // Random traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      in_valid = N'($urandom);
      for (int k = 0; k < N; k++) in_last[k] = ($urandom_range(0, 9) < 4);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      step();
    end
    chk("beat_count", in_beats, out_beats + int'(out_valid));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
